bit_serial_alu: RTL
===================

Name: bit_serial_alu

Overview:
- Multi-cycle, bit-serial counterpart to the 1-bit ALU slice.
- Holds the two 32-bit operands, feeds one bit pair per cycle (LSB first) through a single slice datapath, carries the carry bit between cycles, and assembles the full-width result.
- Produces the overflow, zero and compare flags.
- Sits beside the combinational ALU as an area-reduced alternative, driven by the lab controller through a start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- src1_i  input  WIDTH  operand A; captured when start accepted.
- src2_i  input  WIDTH  operand B; captured when start accepted.
- ctrl_i  input  4  op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SET, 1100 NOR.
- comp_i  input  3  SET compare: 000 LT, 001 GT, 010 LE, 011 GE, 110 EQ, 100 NE.
- busy_o  output  1  high while an operation is in progress.
- done_o  output  1  one-cycle pulse; result and flags valid.
- result_o  output  WIDTH  result; held until next accepted start.
- zero_o  output  1  result_o == 0.
- overflow_o  output  1  signed overflow, ADD/SUB only.
- cout_o  output  1  carry out of MSB.

Behaviour:
- Reset (async assert, sync release): state=IDLE. busy_o, done_o, result_o, overflow_o and cout_o are 0. zero_o=1 (consistent with result 0).
- Decode: A_invert=1 for NOR. B_invert=1 for NOR, SUB and SET. Slice op is AND for AND/NOR, OR for OR, ADD for ADD/SUB/SET.
- Undefined ctrl_i or comp_i values: result 0, flags 0, normal latency.
- IDLE:
  - start_i=1 latches src1/src2/ctrl/comp, sets cnt=0 and carry=B_invert.
  - Next state RUN, busy_o=1 from the next cycle.
- RUN, one bit per cycle:
  - a=A[cnt]^A_invert, b=B[cnt]^B_invert, sum=a^b^carry.
  - carry <= majority(a,b,carry).
  - Bit result (AND/OR/sum) shifts into the result shift register from the MSB side.
  - Track diff_nz |= sum.
  - cnt increments.
- At cnt=WIDTH-1, also register:
  - c_in_msb = incoming carry.
  - sum_msb.
  - a_msb, b_msb (original operand sign bits).
  - Next state FIN.
- FIN:
  - cout = final carry. ovf = c_in_msb ^ cout.
  - less = sum_msb ^ ovf. equal = ~diff_nz.
  - LT=less, GT=~less&~equal, LE=less|equal, GE=~less, EQ=equal, NE=~equal.
  - SET result = {WIDTH-1 zeros, cmp}.
  - overflow_o = ovf for ADD/SUB, 0 otherwise. cout_o = cout for ADD/SUB/SET, 0 otherwise.
  - Outputs update, done_o=1 for this cycle, busy_o drops, next state IDLE.
- Latency: start sampled at edge N; done_o high in the cycle after edge N+WIDTH+1 (WIDTH+2 cycles total).
- Back-to-back: start_i high in the cycle done_o is high is accepted (state is returning to IDLE). Max throughput is one op per WIDTH+2 cycles.
- start_i while busy: ignored. Operand inputs may change freely after acceptance.
- result_o and flags change only at FIN; they hold during a following RUN.
- rst_n low mid-RUN: immediate abort to reset values, no done_o pulse.
- SUB of equal operands: result 0, zero_o=1, cout_o=1, overflow_o=0.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+0x00000001 -> after 34 cycles done_o=1, result_o=0x80000000, overflow_o=1, cout_o=0, zero_o=0.
- SUB 0x00000005-0x00000005 -> result_o=0, zero_o=1, cout_o=1, overflow_o=0.
- SET LT src1=0x80000000, src2=0x00000001 -> result_o=1. SET GT same operands -> 0. SET EQ 0x1234/0x1234 -> 1, NE -> 0.
- NOR 0xF0F0F0F0,0x0F0F0F00 -> 0x0000000F. AND 0xFFFF0000,0x00FFFF00 -> 0x00FF0000. OR same operands -> 0xFFFFFF00.
- start_i held high across an op with operands changed mid-RUN -> result reflects the latched operands only. Second op accepted on the done cycle and completes 34 cycles later.
- rst_n pulsed low at cycle 10 of an ADD -> outputs 0 immediately, zero_o=1, no done_o. A new start after release completes normally.

Source files
------------

// File: rtl/bit_serial_alu_if.sv
// Start/done handshake, operand and result bundle for the bit-serial ALU.
// The controller uses the master modport, the ALU uses the slave modport.
interface bit_serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic [2:0]       comp_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;
  logic             cout_o;

  modport master (
    output start_i, src1_i, src2_i, ctrl_i, comp_i,
    input  busy_o, done_o, result_o, zero_o, overflow_o, cout_o
  );

  modport slave (
    input  start_i, src1_i, src2_i, ctrl_i, comp_i,
    output busy_o, done_o, result_o, zero_o, overflow_o, cout_o
  );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one operand bit pair per cycle through a single 1-bit slice,
// carry kept between cycles, result and flags published together at FIN.
module bit_serial_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_n,
  bit_serial_alu_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SET = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [3:0]       ctrl_q;
  logic [2:0]       comp_q;
  logic             carry_q, diff_nz_q, c_in_msb_q, sum_msb_q;

  function automatic logic op_a_inv(input logic [3:0] op);
    return (op == OP_NOR);
  endfunction

  function automatic logic op_b_inv(input logic [3:0] op);
    return (op == OP_NOR) || (op == OP_SUB) || (op == OP_SET);
  endfunction

  function automatic logic slice_bit(input logic [3:0] op, input logic a,
                                     input logic b, input logic s);
    case (op)
      OP_AND, OP_NOR:         return a & b;
      OP_OR:                  return a | b;
      OP_ADD, OP_SUB, OP_SET: return s;
      default:                return 1'b0;
    endcase
  endfunction

  // Returns {valid, compare bit}; undefined compare codes are flagged invalid.
  function automatic logic [1:0] cmp_sel(input logic [2:0] comp, input logic less,
                                         input logic equal);
    case (comp)
      3'b000:  return {1'b1, less};
      3'b001:  return {1'b1, ~less & ~equal};
      3'b010:  return {1'b1, less | equal};
      3'b011:  return {1'b1, ~less};
      3'b110:  return {1'b1, equal};
      3'b100:  return {1'b1, ~equal};
      default: return 2'b00;
    endcase
  endfunction

  logic accept, last_bit;
  logic a_bit, b_bit, sum_bit, carry_nxt;
  logic ovf_fin, less_fin, equal_fin;
  logic [1:0] cmp_fin;
  logic [WIDTH-1:0] res_fin;
  logic ovf_out, cout_out;

  assign accept    = (state_q == IDLE) && bus.start_i;
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign a_bit     = a_sh[0] ^ op_a_inv(ctrl_q);
  assign b_bit     = b_sh[0] ^ op_b_inv(ctrl_q);
  assign sum_bit   = a_bit ^ b_bit ^ carry_q;
  assign carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

  assign ovf_fin   = c_in_msb_q ^ carry_q;
  assign less_fin  = sum_msb_q ^ ovf_fin;
  assign equal_fin = ~diff_nz_q;
  assign cmp_fin   = cmp_sel(comp_q, less_fin, equal_fin);

  always_comb begin
    res_fin  = '0;
    ovf_out  = 1'b0;
    cout_out = 1'b0;
    case (ctrl_q)
      OP_AND, OP_OR, OP_NOR: res_fin = res_sh;
      OP_ADD, OP_SUB: begin
        res_fin  = res_sh;
        ovf_out  = ovf_fin;
        cout_out = carry_q;
      end
      OP_SET: begin
        if (cmp_fin[1]) begin
          res_fin  = WIDTH'(cmp_fin[0]);
          cout_out = carry_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = RUN;
      RUN:     if (last_bit) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/result shifters and serial carry: no reset, always loaded on accept.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_sh      <= bus.src1_i;
      b_sh      <= bus.src2_i;
      ctrl_q    <= bus.ctrl_i;
      comp_q    <= bus.comp_i;
      carry_q   <= op_b_inv(bus.ctrl_i);
      diff_nz_q <= 1'b0;
    end else if (state_q == RUN) begin
      a_sh      <= a_sh >> 1;
      b_sh      <= b_sh >> 1;
      res_sh    <= {slice_bit(ctrl_q, a_bit, b_bit, sum_bit), res_sh[WIDTH-1:1]};
      carry_q   <= carry_nxt;
      diff_nz_q <= diff_nz_q | sum_bit;
      if (last_bit) begin
        c_in_msb_q <= carry_q;
        sum_msb_q  <= sum_bit;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bus.done_o     <= 1'b0;
      bus.result_o   <= '0;
      bus.zero_o     <= 1'b1;
      bus.overflow_o <= 1'b0;
      bus.cout_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus.done_o <= (state_q == FIN);
      if (accept) cnt_q <= '0;
      else if (state_q == RUN) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == FIN) begin
        bus.result_o   <= res_fin;
        bus.zero_o     <= (res_fin == '0);
        bus.overflow_o <= ovf_out;
        bus.cout_o     <= cout_out;
      end
    end
  end

  assign bus.busy_o = (state_q != IDLE);

endmodule
